// File: rtl/cpu_mem_ctrl.sv
// CPU-side access controller: splits 8/16/32/48-bit CPU accesses into halfword
// memory beats, stalling the CPU through cpu_enable until the access completes.
module cpu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_wr,
    input  logic [1:0]            cpu_req_size,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [47:0]           cpu_wr_data,
    output logic                  cpu_enable,
    output logic [47:0]           cpu_data_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [1:0]            mem_byte_en,
    output logic [15:0]           mem_wr_data,
    input  logic [15:0]           mem_rd_data,
    input  logic                  mem_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            beat_idx_q, beat_idx_d;
    logic [2:0]            beat_cnt_q, beat_cnt_d;
    logic                  off_q, off_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic                  wr_q, wr_d;
    logic [63:0]           wbuf_q, wbuf_d;
    logic [63:0]           rbuf_q, rbuf_d;
    logic                  cpu_enable_q, cpu_enable_d;
    logic [47:0]           cpu_data_in_q, cpu_data_in_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [1:0]            mem_be_q, mem_be_d;
    logic [15:0]           mem_wr_data_q, mem_wr_data_d;

    logic [2:0]            req_nbytes;
    logic [2:0]            req_beats;

    // Lane enables for beat idx: byte k of the halfword window belongs to the
    // access when off <= k < off + nbytes.
    function automatic logic [1:0] lane_en(input logic [1:0] idx, input logic off,
                                           input logic [2:0] nb);
        logic [3:0] lo, hi;
        lo = {1'b0, idx, 1'b0};
        hi = {3'b000, off} + {1'b0, nb};
        lane_en[0] = (lo >= {3'b000, off}) && (lo < hi);
        lane_en[1] = ((lo + 4'd1) >= {3'b000, off}) && ((lo + 4'd1) < hi);
    endfunction

    function automatic logic [47:0] size_mask(input logic [2:0] nb);
        case (nb)
            3'd1:    size_mask = 48'h0000_0000_00FF;
            3'd2:    size_mask = 48'h0000_0000_FFFF;
            3'd4:    size_mask = 48'h0000_FFFF_FFFF;
            default: size_mask = 48'hFFFF_FFFF_FFFF;
        endcase
    endfunction

    always_comb begin
        req_nbytes = 3'd1;
        req_beats  = 3'd1;
        case (cpu_req_size)
            2'd0: begin req_nbytes = 3'd1; req_beats = 3'd1; end
            2'd1: begin req_nbytes = 3'd2; req_beats = cpu_addr[0] ? 3'd2 : 3'd1; end
            2'd2: begin req_nbytes = 3'd4; req_beats = cpu_addr[0] ? 3'd3 : 3'd2; end
            default: begin req_nbytes = 3'd6; req_beats = cpu_addr[0] ? 3'd4 : 3'd3; end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        beat_idx_d    = beat_idx_q;
        beat_cnt_d    = beat_cnt_q;
        off_d         = off_q;
        nbytes_d      = nbytes_q;
        wr_d          = wr_q;
        wbuf_d        = wbuf_q;
        rbuf_d        = rbuf_q;
        cpu_enable_d  = cpu_enable_q;
        cpu_data_in_d = cpu_data_in_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        mem_be_d      = mem_be_q;
        mem_wr_data_d = mem_wr_data_q;
        case (state_q)
            S_IDLE: begin
                cpu_enable_d = 1'b1;
                mem_rd_d     = 1'b0;
                mem_wr_d     = 1'b0;
                mem_be_d     = 2'b00;
                if (cpu_req_valid) begin
                    state_d       = S_BEAT;
                    wr_d          = cpu_req_wr;
                    off_d         = cpu_addr[0];
                    nbytes_d      = req_nbytes;
                    beat_cnt_d    = req_beats;
                    beat_idx_d    = 2'd0;
                    // Pre-shift write data so each beat is a plain 16-bit slice.
                    wbuf_d        = cpu_addr[0] ? {8'h00, cpu_wr_data, 8'h00}
                                                : {16'h0000, cpu_wr_data};
                    rbuf_d        = '0;
                    mem_addr_d    = {cpu_addr[ADDR_WIDTH-1:1], 1'b0};
                    mem_rd_d      = !cpu_req_wr;
                    mem_wr_d      = cpu_req_wr;
                    mem_be_d      = lane_en(2'd0, cpu_addr[0], req_nbytes);
                    mem_wr_data_d = wbuf_d[15:0];
                    cpu_enable_d  = 1'b0;
                end
            end
            S_BEAT: begin
                if (mem_ack) begin
                    if (!wr_q) rbuf_d[{beat_idx_q, 4'b0000} +: 16] = mem_rd_data;
                    if (({1'b0, beat_idx_q} + 3'd1) == beat_cnt_q) begin
                        state_d      = S_DONE;
                        mem_rd_d     = 1'b0;
                        mem_wr_d     = 1'b0;
                        mem_be_d     = 2'b00;
                        cpu_enable_d = 1'b1;
                        if (!wr_q)
                            cpu_data_in_d = (off_q ? rbuf_d[55:8] : rbuf_d[47:0])
                                            & size_mask(nbytes_q);
                    end else begin
                        beat_idx_d    = beat_idx_q + 2'd1;
                        mem_addr_d    = mem_addr_q + ADDR_WIDTH'(2);
                        mem_be_d      = lane_en(beat_idx_d, off_q, nbytes_q);
                        mem_wr_data_d = wbuf_q[{beat_idx_d, 4'b0000} +: 16];
                    end
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                cpu_enable_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beat_idx_q    <= '0;
            beat_cnt_q    <= '0;
            off_q         <= 1'b0;
            nbytes_q      <= '0;
            wr_q          <= 1'b0;
            wbuf_q        <= '0;
            rbuf_q        <= '0;
            cpu_enable_q  <= 1'b0;
            cpu_data_in_q <= '0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_be_q      <= 2'b00;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            beat_idx_q    <= beat_idx_d;
            beat_cnt_q    <= beat_cnt_d;
            off_q         <= off_d;
            nbytes_q      <= nbytes_d;
            wr_q          <= wr_d;
            wbuf_q        <= wbuf_d;
            rbuf_q        <= rbuf_d;
            cpu_enable_q  <= cpu_enable_d;
            cpu_data_in_q <= cpu_data_in_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_be_q      <= mem_be_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign cpu_enable  = cpu_enable_q;
    assign cpu_data_in = cpu_data_in_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_byte_en = mem_be_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Bench for cpu_mem_ctrl: a byte-level memory model produces expected beats and
// read data into queues; observed beats are queued and compared in each test.
module tb_cpu_mem_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  be;
        logic        wr;
        logic [15:0] wd;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_wr = 1'b0;
    logic [1:0]  cpu_req_size = 2'd0;
    logic [31:0] cpu_addr = '0;
    logic [47:0] cpu_wr_data = '0;
    logic        cpu_enable;
    logic [47:0] cpu_data_in;
    logic [31:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_byte_en;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data = '0;
    logic        mem_ack = 1'b0;

    int total = 0;
    int bad = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    logic [47:0] exp_data_q[$];
    logic [47:0] last_rd = '0;

    always #5 clk = ~clk;

    cpu_mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr),
        .cpu_req_size(cpu_req_size), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_enable(cpu_enable), .cpu_data_in(cpu_data_in), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte_en(mem_byte_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
    );

    function automatic logic [7:0] mb(input logic [31:0] a);
        case (a)
            32'h100: mb = 8'h22;
            32'h101: mb = 8'h11;
            32'h102: mb = 8'h44;
            32'h103: mb = 8'h33;
            default: mb = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Reference: expected beats and the cpu_data_in value after the access.
    task automatic model_access(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                input logic [47:0] wd, output int nbeats);
        int off, nb, p;
        beat_t e;
        logic [47:0] d;
        off = int'(a[0]);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 6;
        nbeats = (off + nb + 1) / 2;
        for (int k = 0; k < nbeats; k++) begin
            e.addr = {a[31:1], 1'b0} + 32'(2 * k);
            e.wr = wr;
            e.wd = '0;
            for (int j = 0; j < 2; j++) begin
                p = 2 * k + j - off;
                e.be[j] = (p >= 0) && (p < nb);
                if (wr && e.be[j]) e.wd[8*j +: 8] = wd[8*p +: 8];
            end
            exp_q.push_back(e);
        end
        if (!wr) begin
            d = '0;
            for (int i = 0; i < nb; i++) d[8*i +: 8] = mb(a + 32'(i));
            last_rd = d;
        end
        exp_data_q.push_back(last_rd);
    endtask

    // Drives one CPU access and plays the memory: acks each beat after dly wait
    // cycles (dly=0 means mem_ack tied high). Records beats; no checking here.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                              input logic [47:0] wd, input int dly, input logic hold,
                              output int low, output int unstable, output logic tmo);
        beat_t cur;
        int wcnt;
        logic done;
        cur = '0;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_wr = wr; cpu_req_size = sz;
        cpu_addr = a; cpu_wr_data = wd;
        @(posedge clk); #1;
        if (!hold) cpu_req_valid = 1'b0;
        low = 0; unstable = 0; wcnt = 0; done = 1'b0; tmo = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (cpu_enable) begin
                done = 1'b1;
                cpu_req_valid = 1'b0;
                if (dly != 0) mem_ack = 1'b0;
            end else begin
                low++;
                if (mem_rd || mem_wr) begin
                    if (wcnt == 0) cur = {mem_addr, mem_byte_en, mem_wr, mem_wr_data};
                    else if (cur !== {mem_addr, mem_byte_en, mem_wr, mem_wr_data}) unstable++;
                    if (wcnt == dly) begin
                        mem_ack = 1'b1;
                        mem_rd_data = {mb(mem_addr + 32'd1), mb(mem_addr)};
                        obs_q.push_back(cur);
                        wcnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                        wcnt++;
                    end
                end
            end
        end
        if (!done) tmo = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cpu_enable, mem_rd, mem_wr, mem_byte_en} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl: got en=%b rd=%b wr=%b be=%b exp all 0",
                     cpu_enable, mem_rd, mem_wr, mem_byte_en);
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wr_data !== 16'h0 || cpu_data_in !== 48'h0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wd=%h din=%h exp 0", mem_addr, mem_wr_data,
                     cpu_data_in);
        end
        rst = 1'b0;
        last_rd = '0;
        @(negedge clk);
        total++;
        if (cpu_enable !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_en: got %b exp 1", cpu_enable);
        end
    endtask

    task automatic test_read_aligned;
        int n, low, uns; logic tmo; beat_t e, o; logic [47:0] ed;
        model_access(1'b0, 2'd2, 32'h100, 48'h0, n);
        run_access(1'b0, 2'd2, 32'h100, 48'h0, 0, 1'b0, low, uns, tmo);
        total++;
        if (tmo || low != 2) begin
            bad++; $display("FAIL rd32_enable_low: got %0d tmo=%b exp 2", low, tmo);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            if (o.addr !== e.addr || o.be !== e.be || o.wr !== e.wr) begin
                bad++; $display("FAIL rd32_beat: got %h/%b/%b exp %h/%b/%b", o.addr, o.be, o.wr,
                                e.addr, e.be, e.wr);
            end
        end
        ed = exp_data_q.pop_front(); total++;
        if (cpu_data_in !== ed || ed !== 48'h0000_3344_1122) begin
            bad++; $display("FAIL rd32_data: got %h exp %h", cpu_data_in, ed);
        end
        obs_q.delete();
    endtask

    task automatic test_read_misaligned;
        int n, low, uns; logic tmo; beat_t e, o; logic [47:0] ed;
        model_access(1'b0, 2'd3, 32'h201, 48'h0, n);
        run_access(1'b0, 2'd3, 32'h201, 48'h0, 0, 1'b0, low, uns, tmo);
        total++;
        if (tmo || low != 4 || obs_q.size() != 4) begin
            bad++; $display("FAIL rd48_beats: got low=%0d beats=%0d exp 4", low, obs_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            if (o.addr !== e.addr || o.be !== e.be || o.wr !== e.wr) begin
                bad++; $display("FAIL rd48_beat: got %h/%b exp %h/%b", o.addr, o.be, e.addr, e.be);
            end
        end
        ed = exp_data_q.pop_front(); total++;
        if (cpu_data_in !== ed) begin
            bad++; $display("FAIL rd48_data: got %h exp %h", cpu_data_in, ed);
        end
        obs_q.delete();
    endtask

    task automatic test_write_byte;
        int n, low, uns; logic tmo; beat_t e, o; logic [47:0] ed;
        model_access(1'b1, 2'd0, 32'h301, 48'hAB, n);
        run_access(1'b1, 2'd0, 32'h301, 48'hAB, 0, 1'b0, low, uns, tmo);
        e = exp_q.pop_front(); total++;
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
        if (tmo || low != 1 || o.addr !== 32'h300 || o.be !== 2'b10 || o.wr !== 1'b1 ||
            o.wd[15:8] !== 8'hAB || e.be !== 2'b10) begin
            bad++; $display("FAIL wr8_beat: got %h/%b/%h low=%0d exp 300/10/AB.. low=1",
                            o.addr, o.be, o.wd, low);
        end
        ed = exp_data_q.pop_front(); total++;
        if (cpu_data_in !== ed) begin
            bad++; $display("FAIL wr8_keeps_din: got %h exp %h", cpu_data_in, ed);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wait_states;
        int n, low, uns; logic tmo; beat_t e, o; logic [47:0] ed;
        model_access(1'b0, 2'd1, 32'h11, 48'h0, n);
        run_access(1'b0, 2'd1, 32'h11, 48'h0, 3, 1'b0, low, uns, tmo);
        total++;
        if (tmo || low != 8 || uns != 0) begin
            bad++; $display("FAIL wait_low: got low=%0d unstable=%0d exp 8/0", low, uns);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            if (o.addr !== e.addr || o.be !== e.be || o.wr !== e.wr) begin
                bad++; $display("FAIL wait_beat: got %h/%b exp %h/%b", o.addr, o.be, e.addr, e.be);
            end
        end
        ed = exp_data_q.pop_front(); total++;
        if (cpu_data_in !== ed) begin
            bad++; $display("FAIL wait_data: got %h exp %h", cpu_data_in, ed);
        end
        obs_q.delete();
    endtask

    task automatic test_wrap;
        int n, low, uns; logic tmo; beat_t e, o; logic [47:0] ed;
        model_access(1'b0, 2'd2, 32'hFFFF_FFFE, 48'h0, n);
        run_access(1'b0, 2'd2, 32'hFFFF_FFFE, 48'h0, 1, 1'b0, low, uns, tmo);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            if (tmo || o.addr !== e.addr || o.be !== e.be) begin
                bad++; $display("FAIL wrap_beat: got %h/%b exp %h/%b", o.addr, o.be, e.addr, e.be);
            end
        end
        ed = exp_data_q.pop_front(); total++;
        if (cpu_data_in !== ed) begin
            bad++; $display("FAIL wrap_data: got %h exp %h", cpu_data_in, ed);
        end
        obs_q.delete();
    endtask

    // 48-bit misaligned write with cpu_req_valid held through BEAT and DONE.
    task automatic test_ignore_valid;
        int n, low, uns; logic tmo; beat_t e, o; logic [15:0] lm; logic [47:0] ed;
        model_access(1'b1, 2'd3, 32'h501, 48'hC0FF_EE12_3456, n);
        run_access(1'b1, 2'd3, 32'h501, 48'hC0FF_EE12_3456, 0, 1'b1, low, uns, tmo);
        repeat (2) @(negedge clk);
        total++;
        if (tmo || low != n || obs_q.size() != n || mem_rd || mem_wr) begin
            bad++; $display("FAIL hold_valid: got low=%0d beats=%0d exp %0d", low, obs_q.size(), n);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            lm = {{8{e.be[1]}}, {8{e.be[0]}}};
            if (o.addr !== e.addr || o.be !== e.be || o.wr !== 1'b1 || (o.wd & lm) !== e.wd) begin
                bad++; $display("FAIL wr48_beat: got %h/%b/%h exp %h/%b/%h", o.addr, o.be, o.wd,
                                e.addr, e.be, e.wd);
            end
        end
        ed = exp_data_q.pop_front(); total++;
        if (cpu_data_in !== ed) begin
            bad++; $display("FAIL wr48_keeps_din: got %h exp %h", cpu_data_in, ed);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        int n, low, uns, dly; logic tmo, wr; logic [1:0] sz; logic [31:0] a;
        logic [63:0] r; beat_t e, o; logic [15:0] lm; logic [47:0] ed;
        for (int t = 0; t < 24; t++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = (t % 6 == 5) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom;
            r = {$urandom, $urandom};
            dly = $urandom_range(0, 2);
            model_access(wr, sz, a, r[47:0], n);
            run_access(wr, sz, a, r[47:0], dly, 1'b0, low, uns, tmo);
            total++;
            if (tmo || low != n * (dly + 1) || uns != 0) begin
                bad++; $display("FAIL b2b_timing[%0d]: got low=%0d uns=%0d exp %0d", t, low, uns,
                                n * (dly + 1));
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); total++;
                o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
                lm = {{8{e.be[1] & e.wr}}, {8{e.be[0] & e.wr}}};
                if (o.addr !== e.addr || o.be !== e.be || o.wr !== e.wr || (o.wd & lm) !== e.wd) begin
                    bad++; $display("FAIL b2b_beat[%0d]: got %h/%b/%b/%h exp %h/%b/%b/%h", t,
                                    o.addr, o.be, o.wr, o.wd, e.addr, e.be, e.wr, e.wd);
                end
            end
            ed = exp_data_q.pop_front(); total++;
            if (cpu_data_in !== ed) begin
                bad++; $display("FAIL b2b_data[%0d]: got %h exp %h", t, cpu_data_in, ed);
            end
            total++;
            if (obs_q.size() != 0) begin
                bad++; $display("FAIL b2b_extra_beats[%0d]: got %0d exp 0", t, obs_q.size());
                obs_q.delete();
            end
        end
    endtask

    // Reset during beat 2 of a 3-beat read; the buffered beat must not leak out.
    task automatic test_reset_abort;
        @(negedge clk);
        total++;
        if (cpu_data_in === 48'h0) begin
            bad++; $display("FAIL abort_precond: got din=0 exp nonzero from prior read");
        end
        cpu_req_valid = 1'b1; cpu_req_wr = 1'b0; cpu_req_size = 2'd2; cpu_addr = 32'h401;
        mem_ack = 1'b1; mem_rd_data = 16'hBEEF;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mem_addr !== 32'h402 || mem_rd !== 1'b1) begin
            bad++; $display("FAIL abort_beat2: got addr=%h rd=%b exp 402/1", mem_addr, mem_rd);
        end
        rst = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_rd, mem_wr, mem_byte_en, cpu_enable} !== 5'b0 || cpu_data_in !== 48'h0 ||
            mem_addr !== 32'h0) begin
            bad++; $display("FAIL abort_state: got rd=%b wr=%b be=%b en=%b din=%h addr=%h exp 0",
                            mem_rd, mem_wr, mem_byte_en, cpu_enable, cpu_data_in, mem_addr);
        end
        rst = 1'b0;
        last_rd = '0;
        @(negedge clk);
        total++;
        if (cpu_enable !== 1'b1 || mem_rd !== 1'b0 || cpu_data_in !== 48'h0) begin
            bad++; $display("FAIL abort_recover: got en=%b rd=%b din=%h exp 1/0/0", cpu_enable,
                            mem_rd, cpu_data_in);
        end
    endtask

    initial begin
        test_reset();
        test_read_aligned();
        test_read_misaligned();
        test_write_byte();
        test_wait_states();
        test_ignore_valid();
        test_back_to_back();
        test_wrap();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
